conv_sched: RTL and testbench

Sequencer for the 3×3 convolution engine: waits for a weight load, then walks every output-window position of the input feature map, drives the PE-array valid and window coordinates, and collects PE results into the OFM buffer. It then streams the OFM buffer out on AXI4-Stream with backpressure and `tlast`. The block sits between the DMA-facing control and the PE datapath/OFM RAM, and owns all counters and stream handshakes the datapath needs.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/ofm_stream_out.sv | 90 +++++++++
 rtl/conv_sched.sv | 144 ++++++++++++++
 tb/tb_conv_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the 3x3 convolution sequencer.
// The frame size and the OFM address width both follow from the image dimensions.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_W  = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        SEND    = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int DEF_IMG_W  = 50;
    localparam int DEF_IMG_H  = 50;
    localparam int DEF_PE_LAT = 3;

    // A 3x3 window with no padding yields (W-2)*(H-2) outputs.
    function automatic int ofm_n(input int img_w, input int img_h);
        return (img_w - 2) * (img_h - 2);
    endfunction

    localparam int OFM_N      = ofm_n(DEF_IMG_W, DEF_IMG_H);
    localparam int DEF_OFM_AW = $clog2(OFM_N);

endpackage

// File: rtl/ofm_stream_out.sv
// Streams OFM words 0..n-1 out of a 1-cycle-latency RAM onto AXI4-Stream.
// A two-entry skid buffer absorbs the RAM latency so backpressure never drops or repeats a word.
module ofm_stream_out #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW:0]   n,
    output logic [AW-1:0] raddr,
    input  logic [31:0]   q,
    output logic          tvalid,
    output logic [31:0]   tdata,
    output logic          tlast,
    input  logic          tready,
    output logic          last_accepted
);

    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

    logic          active;
    logic [AW:0]   rd_cnt;
    logic [AW:0]   beat_cnt;
    logic          pend;
    logic [1:0]    cnt;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [31:0]   skid0;
    logic [31:0]   skid1;
    logic          pop;
    logic          issue;
    logic [2:0]    occ;

    // Handshake: a beat moves when tvalid && tready on the same rising edge; once
    // tvalid is high, tdata/tlast hold and tvalid stays high until that edge.
    assign tvalid        = (cnt != 2'd0);
    assign tdata         = rd_ptr ? skid1 : skid0;
    assign tlast         = tvalid && (beat_cnt == (n - CNT_ONE));
    assign pop           = tvalid && tready;
    assign last_accepted = pop && tlast;
    assign raddr         = rd_cnt[AW-1:0];

    // Slots held after this edge: buffered words plus the read in flight, minus the beat leaving.
    assign occ   = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};
    assign issue = active && (rd_cnt < n) && (occ < 3'd2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active   <= 1'b0;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            pend     <= 1'b0;
            cnt      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            skid0    <= '0;
            skid1    <= '0;
        end else if (start) begin
            active   <= 1'b1;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            pend     <= 1'b0;
            cnt      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            if (last_accepted) begin
                active <= 1'b0;
            end
            pend <= issue;
            if (issue) begin
                rd_cnt <= rd_cnt + CNT_ONE;
            end
            if (pend) begin
                if (wr_ptr) begin
                    skid1 <= q;
                end else begin
                    skid0 <= q;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                beat_cnt <= beat_cnt + CNT_ONE;
            end
            cnt <= cnt + {1'b0, pend} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/conv_sched.sv
// Frame sequencer for the 3x3 convolution engine: weight wait, window walk,
// PE drain, then the OFM stream-out. Owns window, write and drain counters.
module conv_sched
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int PE_LAT = DEF_PE_LAT,
    parameter int OFM_AW = DEF_OFM_AW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              wdata_valid,
    output logic              busy,
    output logic              done,
    output logic              pe_valid,
    output logic [5:0]        win_row,
    output logic [5:0]        win_col,
    output logic              ofm_we,
    output logic [OFM_AW-1:0] ofm_waddr,
    output logic [OFM_AW-1:0] ofm_raddr,
    input  logic [31:0]       ofm_q,
    output logic              m_axis_tvalid,
    output logic [31:0]       m_axis_tdata,
    output logic [3:0]        m_axis_tstrb,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [2:0]        dbg_state
);

    localparam int            N        = ofm_n(IMG_W, IMG_H);
    localparam logic [OFM_AW:0] N_W    = (OFM_AW + 1)'(N);
    localparam logic [5:0]    COL_LAST = 6'(IMG_W - 3);
    localparam logic [5:0]    ROW_LAST = 6'(IMG_H - 3);
    localparam int            DW       = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PE_LAT - 1);

    state_t              state_q;
    state_t              state_d;
    logic                w_early;
    logic [DW-1:0]       drain_cnt;
    logic [PE_LAT-1:0]   pe_sr;
    logic                last_win;
    logic                stream_start;
    logic                last_accepted;

    assign last_win = (win_row == ROW_LAST) && (win_col == COL_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WAIT_W;
            WAIT_W:  if (wdata_valid || w_early) state_d = COMPUTE;
            COMPUTE: if (last_win) state_d = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_d = SEND;
            SEND:    if (last_accepted) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        pe_valid     = (state_q == COMPUTE);
        stream_start = (state_q == DRAIN) && (state_d == SEND);
        m_axis_tstrb = 4'b1111;
        dbg_state    = state_q;
    end

    // A weight load landing together with start is remembered for the WAIT_W cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_early   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            w_early   <= (state_q == IDLE) && start && wdata_valid;
            drain_cnt <= (state_q == DRAIN) ? drain_cnt + DW'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_row <= 6'd0;
            win_col <= 6'd0;
        end else if (state_q == COMPUTE) begin
            if (win_col == COL_LAST) begin
                win_col <= 6'd0;
                win_row <= (win_row == ROW_LAST) ? 6'd0 : win_row + 6'd1;
            end else begin
                win_col <= win_col + 6'd1;
            end
        end else begin
            win_row <= 6'd0;
            win_col <= 6'd0;
        end
    end

    // pe_valid delayed by the PE pipeline depth marks when a result is ready to store.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pe_sr     <= '0;
            ofm_waddr <= '0;
        end else begin
            pe_sr[0] <= pe_valid;
            for (int i = 1; i < PE_LAT; i++) begin
                pe_sr[i] <= pe_sr[i-1];
            end
            if (state_q == WAIT_W) begin
                ofm_waddr <= '0;
            end else if (ofm_we) begin
                ofm_waddr <= ofm_waddr + OFM_AW'(1);
            end
        end
    end

    assign ofm_we = pe_sr[PE_LAT-1];

    ofm_stream_out #(
        .AW (OFM_AW)
    ) u_stream (
        .clk           (clk),
        .rstn          (rstn),
        .start         (stream_start),
        .n             (N_W),
        .raddr         (ofm_raddr),
        .q             (ofm_q),
        .tvalid        (m_axis_tvalid),
        .tdata         (m_axis_tdata),
        .tlast         (m_axis_tlast),
        .tready        (m_axis_tready),
        .last_accepted (last_accepted)
    );

endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: a 50x50 instance for full frames (stalls, ignored starts,
// mid-stream reset) and a 5x5 instance for the row-wrap and short-stream corners.
module tb_conv_sched;
    import conv_pkg::*;

    localparam int N  = 2304;
    localparam int NB = 9;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- 50x50 instance ----------------
    logic        a_start = 0, a_wdv = 0, a_tready = 0;
    logic        a_busy, a_done, a_pe_valid, a_we, a_tvalid, a_tlast;
    logic [5:0]  a_row, a_col;
    logic [11:0] a_waddr, a_raddr;
    logic [31:0] a_q = 0, a_tdata;
    logic [3:0]  a_tstrb;
    logic [2:0]  a_dbg;

    conv_sched u_a (
        .clk(clk), .rstn(rstn), .start(a_start), .wdata_valid(a_wdv),
        .busy(a_busy), .done(a_done), .pe_valid(a_pe_valid),
        .win_row(a_row), .win_col(a_col), .ofm_we(a_we), .ofm_waddr(a_waddr),
        .ofm_raddr(a_raddr), .ofm_q(a_q), .m_axis_tvalid(a_tvalid),
        .m_axis_tdata(a_tdata), .m_axis_tstrb(a_tstrb), .m_axis_tlast(a_tlast),
        .m_axis_tready(a_tready), .dbg_state(a_dbg)
    );

    always @(posedge clk) a_q <= 32'hA500_0000 | 32'(a_raddr);

    int pe_cnt, we_cnt, beat_cnt, done_cnt, busy_gap;
    int first_pe, first_we, send_cyc, first_tv, done_cyc;
    logic [5:0]  exp_row, exp_col;
    logic [11:0] exp_waddr;
    logic        in_frame, stalled, held_last;
    logic [31:0] held_data, exp_d;
    logic [31:0] exp_q[$];

    task automatic frame_reset_model();
        pe_cnt = 0; we_cnt = 0; beat_cnt = 0; done_cnt = 0; busy_gap = 0;
        first_pe = -1; first_we = -1; send_cyc = -1; first_tv = -1; done_cyc = -1;
        exp_row = 0; exp_col = 0; exp_waddr = 0;
        in_frame = 0; stalled = 0; held_last = 0; held_data = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(32'hA500_0000 | 32'(i));
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (a_busy) in_frame = 1;
            else if (in_frame) busy_gap++;
            if (a_pe_valid) begin
                if (pe_cnt == 0) first_pe = cyc;
                check("window", {a_row, a_col}, {exp_row, exp_col});
                if (exp_col == 6'd47) begin
                    exp_col = 0;
                    exp_row = exp_row + 6'd1;
                end else begin
                    exp_col = exp_col + 6'd1;
                end
                pe_cnt++;
            end
            if (a_we) begin
                if (we_cnt == 0) first_we = cyc;
                check("waddr", a_waddr, exp_waddr);
                exp_waddr = exp_waddr + 12'd1;
                we_cnt++;
            end
            if (a_dbg == SEND) begin
                if (send_cyc < 0) send_cyc = cyc;
                check("raddr_ahead", (int'(a_raddr) >= beat_cnt) && (int'(a_raddr) - beat_cnt <= 2), 1);
            end
            if (a_tvalid && first_tv < 0) first_tv = cyc;
            if (stalled) begin
                check("hold_valid", a_tvalid, 1);
                if (a_tvalid) check("hold_beat", {a_tlast, a_tdata}, {held_last, held_data});
            end
            stalled   = a_tvalid && !a_tready;
            held_data = a_tdata;
            held_last = a_tlast;
            if (a_tvalid && a_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("beat_data", a_tdata, exp_d);
                end
                check("tlast", a_tlast, beat_cnt == N - 1);
                beat_cnt++;
            end
            if (a_done) begin
                done_cnt++;
                done_cyc = cyc;
                in_frame = 0;
            end
        end
    end

    // mode 0: tready=1 with stray starts; 1: stall pattern; 2: reset near beat 1000; 3: tready=1
    task automatic run_a(input int mode);
        int wdv_cyc;
        int hold0, holdl;
        logic [15:0] pat;
        logic aborted;
        hold0 = 0; holdl = 0; aborted = 0;
        pat = 16'b1011_0010_0110_1001;
        frame_reset_model();
        @(posedge clk); #1;
        a_start  = 1;
        a_tready = (mode != 1);
        @(posedge clk); #1;
        a_start = 0;
        repeat (2) @(posedge clk);
        #1;
        a_wdv   = 1;
        wdv_cyc = cyc;
        @(posedge clk); #1;
        a_wdv = 0;
        for (int k = 0; k < 20000; k++) begin
            if (done_cnt != 0) break;
            @(posedge clk); #1;
            a_start = (mode == 0) && (((a_dbg == COMPUTE) && (pe_cnt == 100)) ||
                                      ((a_dbg == SEND) && (beat_cnt == 100)));
            if (mode == 1) begin
                if (beat_cnt == 0 && a_tvalid && hold0 < 20) begin
                    a_tready = 0;
                    hold0++;
                end else if (beat_cnt == N - 1 && a_tvalid && holdl < 20) begin
                    a_tready = 0;
                    holdl++;
                end else begin
                    a_tready = pat[k % 16];
                end
            end
            if (mode == 2 && beat_cnt == 1000) begin
                rstn = 0;
                #1;
                check("abort_ctl", {a_busy, a_done, a_pe_valid, a_we, a_tvalid, a_tlast, a_dbg}, 0);
                check("abort_addr", {a_waddr, a_raddr}, 0);
                check("abort_tdata", a_tdata, 0);
                check("abort_tstrb", a_tstrb, 4'hF);
                @(posedge clk); #1;
                rstn    = 1;
                aborted = 1;
                break;
            end
        end
        a_start = 0;
        repeat (3) @(posedge clk);
        #1;
        if (mode == 2) begin
            check("abort_reached", aborted, 1);
            check("abort_idle", a_busy, 0);
        end else begin
            check("pe_count", pe_cnt, N);
            check("we_count", we_cnt, N);
            check("beat_count", beat_cnt, N);
            check("done_count", done_cnt, 1);
            check("exp_left", exp_q.size(), 0);
            check("busy_gap", busy_gap, 0);
            check("first_pe_lat", first_pe - wdv_cyc, 1);
            check("first_we_lat", first_we - first_pe, 3);
            check("first_tv_lat", first_tv - send_cyc, 2);
            if (mode != 1) check("send_to_done", done_cyc - send_cyc, N + 2);
            check("idle_after", {a_busy, a_dbg}, 0);
        end
    endtask

    // ---------------- 5x5 instance ----------------
    logic        b_start = 0, b_wdv = 0, b_tready = 1;
    logic        b_busy, b_done, b_pe_valid, b_we, b_tvalid, b_tlast;
    logic [5:0]  b_row, b_col;
    logic [3:0]  b_waddr, b_raddr;
    logic [31:0] b_q = 0, b_tdata;
    logic [3:0]  b_tstrb;
    logic [2:0]  b_dbg;

    conv_sched #(.IMG_W(5), .IMG_H(5), .PE_LAT(1), .OFM_AW(4)) u_b (
        .clk(clk), .rstn(rstn), .start(b_start), .wdata_valid(b_wdv),
        .busy(b_busy), .done(b_done), .pe_valid(b_pe_valid),
        .win_row(b_row), .win_col(b_col), .ofm_we(b_we), .ofm_waddr(b_waddr),
        .ofm_raddr(b_raddr), .ofm_q(b_q), .m_axis_tvalid(b_tvalid),
        .m_axis_tdata(b_tdata), .m_axis_tstrb(b_tstrb), .m_axis_tlast(b_tlast),
        .m_axis_tready(b_tready), .dbg_state(b_dbg)
    );

    always @(posedge clk) b_q <= 32'hB000_0000 | 32'(b_raddr);

    logic [11:0] b_win[$];
    logic [31:0] b_beats[$];
    int b_last_cnt = 0, b_last_idx = -1, b_first_pe = -1, b_done_cnt = 0, b_we_cnt = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (b_pe_valid) begin
                if (b_first_pe < 0) b_first_pe = cyc;
                b_win.push_back({b_row, b_col});
            end
            if (b_we) b_we_cnt++;
            if (b_tvalid && b_tready) begin
                b_beats.push_back(b_tdata);
                if (b_tlast) begin
                    b_last_cnt++;
                    b_last_idx = b_beats.size() - 1;
                end
            end
            if (b_done) b_done_cnt++;
        end
    end

    task automatic run_b();
        int st_cyc;
        @(posedge clk); #1;
        b_start = 1;
        b_wdv   = 1;
        st_cyc  = cyc;
        @(posedge clk); #1;
        b_start = 0;
        b_wdv   = 0;
        for (int k = 0; k < 200; k++) begin
            if (b_done_cnt != 0) break;
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("b_first_pe", b_first_pe - st_cyc, 2);
        check("b_win_count", b_win.size(), NB);
        if (b_win.size() == NB) begin
            check("b_win2", b_win[2], {6'd0, 6'd2});
            check("b_win3", b_win[3], {6'd1, 6'd0});
            check("b_win8", b_win[8], {6'd2, 6'd2});
        end
        check("b_we_count", b_we_cnt, NB);
        check("b_beat_count", b_beats.size(), NB);
        for (int i = 0; i < b_beats.size(); i++) check("b_beat", b_beats[i], 32'hB000_0000 | 32'(i));
        check("b_tlast_count", b_last_cnt, 1);
        check("b_tlast_idx", b_last_idx, NB - 1);
        check("b_done_count", b_done_cnt, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl_a", {a_busy, a_done, a_pe_valid, a_we, a_tvalid, a_tlast, a_dbg}, 0);
        check("rst_pos_a", {a_row, a_col}, 0);
        check("rst_addr_a", {a_waddr, a_raddr}, 0);
        check("rst_tdata_a", a_tdata, 0);
        check("rst_tstrb_a", a_tstrb, 4'hF);
        check("rst_ctl_b", {b_busy, b_done, b_pe_valid, b_we, b_tvalid, b_tlast, b_dbg, b_waddr, b_raddr}, 0);
        check("rst_tstrb_b", b_tstrb, 4'hF);
        rstn = 1;
        @(posedge clk); #1;
        run_a(0);
        run_b();
        run_a(1);
        run_a(2);
        run_a(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
